// File: rtl/stoch_div_sched.sv
// -----------------------------------------------------------------------------
// stoch_div_sched
//
// Run controller for the element-wise stochastic divider array. A start
// request clears the divider array for one cycle. The controller then runs
// WARMUP_CYCLES bits so the divider feedback counters settle, and then runs
// len_q bits while it counts the ones on every divider output. The result is a
// per-element binary estimate of A./B.
//
// Optional feature: define STOCH_DIV_SCHED_ABORT_EN to add the `abort` input
// and the `aborted` status output (early termination of a run).
//
// Ports:
//   CLK        in   1                          clock, rising edge
//   RST        in   1                          synchronous active-high reset
//   start      in   1                          run request (sampled in IDLE/DONE)
//   num_bits   in   BITS_WIDTH                 run length, captured on start
//   abort      in   1                          (ABORT_EN only) terminate run
//   aborted    out  1                          (ABORT_EN only) last run aborted
//   busy       out  1                          high in CLEAR/WARMUP/RUN
//   done       out  1                          high in DONE
//   div_nRST   out  1                          active-low divider array reset
//   stream_en  out  1                          bitstream generator advance
//   Y          in   NUM_ROWS*NUM_COLS          divider outputs, (i,j) at i*NUM_COLS+j
//   counts     out  NUM_ROWS*NUM_COLS*COUNT_WIDTH  packed ones counts
// -----------------------------------------------------------------------------
module stoch_div_sched #(
    parameter int NUM_ROWS      = 2,
    parameter int NUM_COLS      = 2,
    parameter int BITS_WIDTH    = 10,
    parameter int WARMUP_CYCLES = 16,
    parameter int COUNT_WIDTH   = BITS_WIDTH + 1
) (
    input  logic                                        CLK,
    input  logic                                        RST,
    input  logic                                        start,
    input  logic [BITS_WIDTH-1:0]                       num_bits,
`ifdef STOCH_DIV_SCHED_ABORT_EN
    input  logic                                        abort,
    output logic                                        aborted,
`endif
    output logic                                        busy,
    output logic                                        done,
    output logic                                        div_nRST,
    output logic                                        stream_en,
    input  logic [NUM_ROWS*NUM_COLS-1:0]                Y,
    output logic [NUM_ROWS*NUM_COLS*COUNT_WIDTH-1:0]    counts
);

    localparam int NUM_EL = NUM_ROWS * NUM_COLS;
    // Warm-up counter needs to hold WARMUP_CYCLES itself; keep at least 1 bit.
    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES + 1) : 1;

    if (COUNT_WIDTH < BITS_WIDTH) begin : g_bad_count_width
        $error("stoch_div_sched: COUNT_WIDTH must be >= BITS_WIDTH");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WARMUP,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [BITS_WIDTH-1:0]   len_q;
    logic [BITS_WIDTH-1:0]   run_cnt_q;
    logic [WARM_W-1:0]       warm_cnt_q;
    logic [COUNT_WIDTH-1:0]  cnt_q [NUM_EL];
    logic                    accept;
    logic                    abort_hit;

    // A start is only honoured when no run is in progress; it is not queued.
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef STOCH_DIV_SCHED_ABORT_EN
    assign abort_hit = abort &&
                       ((state_q == S_CLEAR) || (state_q == S_WARMUP) || (state_q == S_RUN));
`else
    assign abort_hit = 1'b0;
`endif

    // ---- next-state decode ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (WARMUP_CYCLES > 0)    state_d = S_WARMUP;
                else if (len_q != '0)     state_d = S_RUN;
                else                      state_d = S_DONE;
            end
            S_WARMUP: begin
                if (warm_cnt_q == WARM_W'(1)) begin
                    state_d = (len_q != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (run_cnt_q == BITS_WIDTH'(1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_DONE;
    end

    // ---- state, length and phase counters; outputs registered from state_d ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            run_cnt_q  <= '0;
            warm_cnt_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_nRST   <= 1'b0;
            stream_en  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) len_q <= num_bits;

            if ((state_d == S_WARMUP) && (state_q != S_WARMUP)) begin
                warm_cnt_q <= WARM_W'(WARMUP_CYCLES);
            end else if (state_q == S_WARMUP) begin
                warm_cnt_q <= warm_cnt_q - WARM_W'(1);
            end

            // len_q is already a flop when RUN is entered, so it is safe to load.
            if ((state_d == S_RUN) && (state_q != S_RUN)) begin
                run_cnt_q <= len_q;
            end else if (state_q == S_RUN) begin
                run_cnt_q <= run_cnt_q - BITS_WIDTH'(1);
            end

            busy      <= (state_d == S_CLEAR) || (state_d == S_WARMUP) || (state_d == S_RUN);
            done      <= (state_d == S_DONE);
            // Array stays in reset while IDLE; DONE only freezes it.
            div_nRST  <= (state_d == S_WARMUP) || (state_d == S_RUN) || (state_d == S_DONE);
            stream_en <= (state_d == S_WARMUP) || (state_d == S_RUN);
        end
    end

`ifdef STOCH_DIV_SCHED_ABORT_EN
    always_ff @(posedge CLK) begin
        if (RST)            aborted <= 1'b0;
        else if (accept)    aborted <= 1'b0;
        else if (abort_hit) aborted <= 1'b1;
    end
`endif

    // ---- per-element ones counters ----
    always_ff @(posedge CLK) begin
        for (int k = 0; k < NUM_EL; k++) begin
            if (RST || accept) begin
                cnt_q[k] <= '0;
            end else if (state_q == S_RUN) begin
                cnt_q[k] <= cnt_q[k] + COUNT_WIDTH'(Y[k]);
            end
        end
    end

    for (genvar g = 0; g < NUM_EL; g++) begin : g_pack
        assign counts[g*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[g];
    end

endmodule

// File: tb/tb_stoch_div_sched.sv
// -----------------------------------------------------------------------------
// tb_stoch_div_sched
//
// Three controllers (WARMUP_CYCLES = 4, 0, 2) share one stimulus stream; each
// directed vector names the instance whose latency and counts are checked.
// -----------------------------------------------------------------------------
module tb_stoch_div_sched;

    localparam int CW = 11;
    localparam int NE = 4;
    localparam int YM_ONES = 0;
    localparam int YM_ZERO = 1;
    localparam int YM_PAT  = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic            start;
    logic [9:0]      num_bits;
    logic [3:0]      Y;
    logic [2:0]      busy_v, done_v, nrst_v, sen_v;
    logic [NE*CW-1:0] counts_v [3];
`ifdef STOCH_DIV_SCHED_ABORT_EN
    logic            abort;
    logic [2:0]      aborted_v;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

`ifdef STOCH_DIV_SCHED_ABORT_EN
    `define ABORT_PORTS(i) .abort(abort), .aborted(aborted_v[i]),
`else
    `define ABORT_PORTS(i)
`endif

    stoch_div_sched #(.NUM_ROWS(2), .NUM_COLS(2), .BITS_WIDTH(10), .WARMUP_CYCLES(4)) u_w4 (
        .CLK(CLK), .RST(RST), .start(start), .num_bits(num_bits), `ABORT_PORTS(0)
        .busy(busy_v[0]), .done(done_v[0]), .div_nRST(nrst_v[0]), .stream_en(sen_v[0]),
        .Y(Y), .counts(counts_v[0]));

    stoch_div_sched #(.NUM_ROWS(2), .NUM_COLS(2), .BITS_WIDTH(10), .WARMUP_CYCLES(0)) u_w0 (
        .CLK(CLK), .RST(RST), .start(start), .num_bits(num_bits), `ABORT_PORTS(1)
        .busy(busy_v[1]), .done(done_v[1]), .div_nRST(nrst_v[1]), .stream_en(sen_v[1]),
        .Y(Y), .counts(counts_v[1]));

    stoch_div_sched #(.NUM_ROWS(2), .NUM_COLS(2), .BITS_WIDTH(10), .WARMUP_CYCLES(2)) u_w2 (
        .CLK(CLK), .RST(RST), .start(start), .num_bits(num_bits), `ABORT_PORTS(2)
        .busy(busy_v[2]), .done(done_v[2]), .div_nRST(nrst_v[2]), .stream_en(sen_v[2]),
        .Y(Y), .counts(counts_v[2]));

    typedef struct {
        int              sel;      // 0: W=4, 1: W=0, 2: W=2
        int              nb;
        int              ymode;
        int              pulse_c;  // cycle of a start pulse while busy (0 = none)
        int              exp_lat;  // start edge -> first done cycle
        logic [NE*CW-1:0] exp_cnt; // {elem3, elem2, elem1, elem0}
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ypat(input int mode, input int c);
        logic b0;
        case (mode)
            YM_ONES: return 4'hF;
            YM_ZERO: return 4'h0;
            default: begin
                if (c == 1) return 4'hF;     // CLEAR cycle: must not be counted
                if (c < 1)  return 4'h0;
                b0 = (((c - 2) % 2) == 0);
                return {1'b1, 2'b00, b0};
            end
        endcase
    endfunction

    function automatic logic [NE*CW-1:0] all_cnt(input int v);
        logic [NE*CW-1:0] r;
        for (int k = 0; k < NE; k++) r[k*CW +: CW] = CW'(v);
        return r;
    endfunction

    task automatic chk_counts(input string name, input int sel, input logic [NE*CW-1:0] exp);
        for (int k = 0; k < NE; k++) begin
            chk($sformatf("%s_cnt%0d", name, k), 64'(counts_v[sel][k*CW +: CW]),
                64'(exp[k*CW +: CW]));
        end
    endtask

    task automatic wait_all_done(input string name);
        int n = 0;
        @(negedge CLK);
        while (!(&done_v) && n < 1200) begin
            @(negedge CLK);
            n++;
        end
        chk({name, "_all_done"}, 64'(&done_v), 64'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  c;
        int  lat;
        bit  seen;
        string nm;
        nm   = $sformatf("vec%0d", idx);
        @(negedge CLK);
        start    = 1'b1;
        num_bits = 10'(v.nb);
        Y        = ypat(v.ymode, 0);
        @(posedge CLK);
        #1;
        num_bits = ~10'(v.nb);          // must not affect the accepted run
        c    = 1;
        seen = 0;
        lat  = -1;
        while (c < 1200) begin
            Y     = ypat(v.ymode, c);
            start = (c == v.pulse_c);
            @(negedge CLK);
            if (c == 1) begin
                chk({nm, "_clear_nrst"}, 64'(nrst_v[v.sel]), 64'd0);
                chk({nm, "_clear_sen"},  64'(sen_v[v.sel]),  64'd0);
                chk({nm, "_clear_busy"}, 64'(busy_v[v.sel]), 64'd1);
                chk_counts({nm, "_clear"}, v.sel, '0);
            end
            if (!seen && done_v[v.sel]) begin
                seen = 1;
                lat  = c;
            end
            if (seen && (&done_v) && c > v.pulse_c + 1) break;
            @(posedge CLK);
            #1;
            c++;
        end
        start = 1'b0;
        chk({nm, "_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({nm, "_done_busy"}, 64'(busy_v[v.sel]), 64'd0);
        chk({nm, "_done_nrst"}, 64'(nrst_v[v.sel]), 64'd1);
        chk({nm, "_done_sen"},  64'(sen_v[v.sel]),  64'd0);
        chk_counts(nm, v.sel, v.exp_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // W=4 N=8 all ones: latency 2+4+8
        vecs[0] = '{0, 8,    YM_ONES, 0, 14,   all_cnt(8)};
        // W=0 N=10 toggling Y[0], Y[3]=1
        vecs[1] = '{1, 10,   YM_PAT,  0, 12,   {11'd10, 11'd0, 11'd0, 11'd5}};
        // zero-length run goes CLEAR -> WARMUP -> DONE
        vecs[2] = '{0, 0,    YM_ONES, 0, 6,    all_cnt(0)};
        vecs[3] = '{2, 5,    YM_ONES, 0, 9,    all_cnt(5)};
        // W=0 and N=0: CLEAR -> DONE
        vecs[4] = '{1, 0,    YM_ONES, 0, 2,    all_cnt(0)};
        // longest run: counts reach 2^BITS_WIDTH-1
        vecs[5] = '{2, 1023, YM_ONES, 0, 1027, all_cnt(1023)};
        vecs[6] = '{0, 7,    YM_ZERO, 0, 13,   all_cnt(0)};
        // start pulse mid-run is ignored
        vecs[7] = '{0, 8,    YM_ONES, 6, 14,   all_cnt(8)};
        vecs[8] = '{1, 1,    YM_ONES, 0, 3,    all_cnt(1)};

        RST      = 1'b1;
        start    = 1'b0;
        num_bits = '0;
        Y        = '0;
`ifdef STOCH_DIV_SCHED_ABORT_EN
        abort    = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy%0d", i), 64'(busy_v[i]), 64'd0);
            chk($sformatf("rst_done%0d", i), 64'(done_v[i]), 64'd0);
            chk($sformatf("rst_nrst%0d", i), 64'(nrst_v[i]), 64'd0);
            chk($sformatf("rst_sen%0d",  i), 64'(sen_v[i]),  64'd0);
            chk($sformatf("rst_cnt%0d",  i), 64'(counts_v[i] != '0), 64'd0);
        end

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // ---- start held high: W=2, N=3 -> one run every 1+W+N+1 = 7 cycles ----
        begin
            int rises = 0;
            int last  = -1;
            bit prev  = 1'b1;
            @(negedge CLK);
            start    = 1'b1;
            num_bits = 10'd3;
            Y        = 4'hF;
            for (int c = 0; c < 40; c++) begin
                @(negedge CLK);
                if (done_v[2] && !prev) begin
                    if (last >= 0) chk("held_period", 64'(c - last), 64'd7);
                    last = c;
                    rises++;
                    chk_counts("held_done", 2, all_cnt(3));
                end
                if (!done_v[2] && prev) begin
                    chk("held_clear_nrst", 64'(nrst_v[2]), 64'd0);
                    chk_counts("held_clear", 2, '0);
                end
                prev = done_v[2];
            end
            chk("held_rises", 64'(rises >= 4), 64'd1);
            start = 1'b0;
            wait_all_done("held");
        end

        // ---- RST in RUN cycle 5 of 8 (W=4: RUN spans cycles 6..13) ----
        @(negedge CLK);
        start    = 1'b1;
        num_bits = 10'd8;
        Y        = 4'hF;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        chk("midrun_busy", 64'(busy_v[0]), 64'd1);
        chk("midrun_sen",  64'(sen_v[0]),  64'd1);
        chk("midrun_cnt",  64'(counts_v[0][CW-1:0]), 64'd4);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("midrun_rst_busy", 64'(busy_v), 64'd0);
        chk("midrun_rst_done", 64'(done_v), 64'd0);
        chk("midrun_rst_nrst", 64'(nrst_v), 64'd0);
        chk("midrun_rst_sen",  64'(sen_v),  64'd0);
        chk_counts("midrun_rst", 0, '0);
        #1;
        RST = 1'b0;

`ifdef STOCH_DIV_SCHED_ABORT_EN
        // ---- abort in RUN cycle 3 of 8 (W=4: RUN cycles 6,7,8) ----
        @(negedge CLK);
        start    = 1'b1;
        num_bits = 10'd8;
        Y        = 4'hF;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        abort = 1'b1;
        @(posedge CLK);
        #1;
        abort = 1'b0;
        @(negedge CLK);
        chk("abort_done",    64'(done_v[0]),    64'd1);
        chk("abort_aborted", 64'(aborted_v[0]), 64'd1);
        chk_counts("abort", 0, all_cnt(3));
        @(negedge CLK);
        chk_counts("abort_hold", 0, all_cnt(3));
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        @(negedge CLK);
        chk("abort_cleared", 64'(aborted_v[0]), 64'd0);
        wait_all_done("abort_next");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
